// File: rtl/jtag_ir_dr_core.sv
// JTAG instruction register, decoder, BYPASS/IDCODE data registers and user DR port.
// Optional IDCODE register is built when macro JTAG_IDCODE_EN is defined.
module jtag_ir_dr_core #(
   parameter int                  IR_WIDTH     = 5,
   parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
   parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(5'h01),
   parameter logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(5'h10)
) (
   input  logic                tck,
   input  logic                reset,
   input  logic                tdi,
   input  logic                select,
   input  logic                capture_ir,
   input  logic                shift_ir,
   input  logic                update_ir,
   input  logic                capture_dr,
   input  logic                shift_dr,
   input  logic                update_dr,
   input  logic                tdo_en,
   output logic                tdo,
   output logic [IR_WIDTH-1:0] instr,
   output logic                user_sel,
   output logic                user_capture,
   output logic                user_shift,
   output logic                user_update,
   input  logic                user_tdo
);

   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] RESET_INSTR = INSTR_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] RESET_INSTR = '1;
`endif

   logic [IR_WIDTH-1:0] r_ir_sr;
   logic [IR_WIDTH-1:0] r_instr;
   logic                r_bypass;
   logic                r_tdo;
   logic                w_sel_user;
   logic                w_sel_idcode;
   logic                w_sel_bypass;
   logic                w_idcode_lsb;
   logic                w_src;

   // instr only moves in Update-IR; capture/shift act on the shadow shift register
   always_ff @(posedge tck) begin
      if (reset) begin
         r_ir_sr <= '0;
         r_instr <= RESET_INSTR;
      end else begin
         if (update_ir)
            r_instr <= r_ir_sr;
         if (capture_ir)
            r_ir_sr <= IR_CAPTURE;
         else if (shift_ir)
            r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
      end
   end

   assign w_sel_user   = (r_instr == INSTR_USER);
   assign w_sel_bypass = !w_sel_user && !w_sel_idcode;

   always_ff @(posedge tck) begin
      if (reset)
         r_bypass <= 1'b0;
      else if (w_sel_bypass) begin
         if (capture_dr)
            r_bypass <= 1'b0;
         else if (shift_dr)
            r_bypass <= tdi;
      end
   end

`ifdef JTAG_IDCODE_EN
   logic [31:0] r_idcode_sr;

   assign w_sel_idcode = (r_instr == INSTR_IDCODE) && !w_sel_user;
   assign w_idcode_lsb = r_idcode_sr[0];

   always_ff @(posedge tck) begin
      if (reset)
         r_idcode_sr <= '0;
      else if (w_sel_idcode) begin
         if (capture_dr)
            r_idcode_sr <= IDCODE_VALUE;
         else if (shift_dr)
            r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
      end
   end
`else
   // IDCODE opcode falls through to BYPASS; parameters kept for interface compatibility
   logic w_unused_cfg;
   assign w_unused_cfg = ^{IDCODE_VALUE, INSTR_IDCODE};
   assign w_sel_idcode = 1'b0;
   assign w_idcode_lsb = 1'b0;
`endif

   always_comb begin
      w_src = r_bypass;
      if (select)
         w_src = r_ir_sr[0];
      else if (w_sel_user)
         w_src = user_tdo;
      else if (w_sel_idcode)
         w_src = w_idcode_lsb;
   end

   // launched on the falling edge so the host samples a stable bit on the next rise
   always_ff @(negedge tck) begin
      if (reset)
         r_tdo <= 1'b0;
      else
         r_tdo <= tdo_en ? w_src : 1'b0;
   end

   assign tdo          = r_tdo;
   assign instr        = r_instr;
   assign user_sel     = w_sel_user;
   assign user_capture = capture_dr && w_sel_user;
   assign user_shift   = shift_dr   && w_sel_user;
   assign user_update  = update_dr  && w_sel_user;

endmodule

// File: tb/tb_jtag_ir_dr_core.sv
// Self-checking bench for jtag_ir_dr_core: queue-based chain model plus literal scan results.
// Honours JTAG_IDCODE_EN the same way as the design.
module tb_jtag_ir_dr_core;

   localparam int          W   = 5;
   localparam logic [31:0] ID  = 32'h1000_0001;
   localparam int          IDC = 1;
   localparam int          USR = 16;
`ifdef JTAG_IDCODE_EN
   localparam int          RST_INSTR = 1;
`else
   localparam int          RST_INSTR = 31;
`endif

   logic         tck = 1'b0;
   logic         reset, tdi, select;
   logic         capture_ir, shift_ir, update_ir;
   logic         capture_dr, shift_dr, update_dr;
   logic         tdo_en, tdo, user_tdo;
   logic [W-1:0] instr;
   logic         user_sel, user_capture, user_shift, user_update;

   jtag_ir_dr_core #(
      .IR_WIDTH    (W),
      .IDCODE_VALUE(ID),
      .INSTR_IDCODE(5'h01),
      .INSTR_USER  (5'h10)
   ) dut (
      .tck(tck), .reset(reset), .tdi(tdi), .select(select),
      .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .tdo_en(tdo_en), .tdo(tdo), .instr(instr), .user_sel(user_sel),
      .user_capture(user_capture), .user_shift(user_shift), .user_update(user_update),
      .user_tdo(user_tdo)
   );

   always #5 tck = ~tck;

   int n_chk = 0;
   int n_err = 0;
   bit g_chk = 0;

   // Model: each chain is a queue of bits, front = bit that goes out next
   int m_instr;
   bit m_ir[$];
   bit m_byp;
   bit m_id[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int chain_of(input int ins);
      if (ins == USR) return 2;
`ifdef JTAG_IDCODE_EN
      if (ins == IDC) return 1;
`endif
      return 0;
   endfunction

   function automatic int ir_val();
      int v = 0;
      foreach (m_ir[i]) v = v | (int'(m_ir[i]) << i);
      return v;
   endfunction

   task automatic model_reset();
      m_instr = RST_INSTR;
      m_ir.delete();
      for (int i = 0; i < W; i++) m_ir.push_back(1'b0);
      m_byp = 1'b0;
      m_id.delete();
      for (int i = 0; i < 32; i++) m_id.push_back(1'b0);
   endtask

   // One TAP cycle: drive after the rising edge, check strobes, check tdo after the falling edge
   task automatic cyc(input bit rst, input bit cir, input bit sir, input bit uir,
                      input bit cdr, input bit sdr, input bit udr, input bit din,
                      output bit tq);
      bit sel, ut, etdo, is_user;
      int ch;
      sel = cir | sir | uir;
      ut  = 1'($urandom_range(0, 1));
      reset = rst; select = sel; tdi = din; user_tdo = ut;
      capture_ir = cir; shift_ir = sir; update_ir = uir;
      capture_dr = cdr; shift_dr = sdr; update_dr = udr;
      tdo_en = sir | sdr;
      #1;
      ch = chain_of(m_instr);
      is_user = (m_instr == USR);
      if (g_chk) begin
         chk("instr", instr, m_instr);
         chk("user_sel", user_sel, is_user);
         chk("user_capture", user_capture, cdr && is_user);
         chk("user_shift", user_shift, sdr && is_user);
         chk("user_update", user_update, udr && is_user);
      end
      if (rst || !(sir | sdr)) etdo = 1'b0;
      else if (sel)            etdo = m_ir[0];
      else if (ch == 2)        etdo = ut;
      else if (ch == 1)        etdo = m_id[0];
      else                     etdo = m_byp;
      @(negedge tck); #1;
      tq = tdo;
      if (g_chk || rst) chk("tdo", tdo, etdo);
      @(posedge tck);
      if (rst) model_reset();
      else begin
         if (uir) m_instr = ir_val();
         if (cir) begin
            m_ir.delete();
            for (int i = 0; i < W; i++) m_ir.push_back(i == 0);
         end else if (sir) begin
            void'(m_ir.pop_front());
            m_ir.push_back(din);
         end
         if (ch == 0) begin
            if (cdr)      m_byp = 1'b0;
            else if (sdr) m_byp = din;
         end else if (ch == 1) begin
            if (cdr) begin
               m_id.delete();
               for (int i = 0; i < 32; i++) m_id.push_back(ID[i]);
            end else if (sdr) begin
               void'(m_id.pop_front());
               m_id.push_back(din);
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      bit t;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, t);
   endtask

   task automatic ir_scan(input logic [4:0] v, output logic [4:0] o);
      bit t;
      o = '0;
      cyc(0, 1, 0, 0, 0, 0, 0, 0, t);
      for (int i = 0; i < W; i++) begin
         cyc(0, 0, 1, 0, 0, 0, 0, v[i], t);
         o[i] = t;
      end
      cyc(0, 0, 0, 1, 0, 0, 0, 0, t);
   endtask

   task automatic dr_scan(input int n, input logic [63:0] d, output logic [63:0] o);
      bit t;
      o = '0;
      cyc(0, 0, 0, 0, 1, 0, 0, 0, t);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 0, 0, 0, 1, 0, d[i], t);
         o[i] = t;
      end
      cyc(0, 0, 0, 0, 0, 0, 1, 0, t);
   endtask

   initial begin
      logic [4:0]  o5, op;
      logic [63:0] d, o;
      bit          t;
      int          pick, n;

      reset = 1'b1; tdi = 0; select = 0; tdo_en = 0; user_tdo = 0;
      capture_ir = 0; shift_ir = 0; update_ir = 0;
      capture_dr = 0; shift_dr = 0; update_dr = 0;
      model_reset();
      @(posedge tck); #1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, t);
      g_chk = 1;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, t);
      chk("rst_instr", instr, RST_INSTR);
      idle(2);

      // first DR scan after reset
      d = {$urandom, $urandom};
      dr_scan(32, d, o);
`ifdef JTAG_IDCODE_EN
      chk("idcode_word", o[31:0], 32'h1000_0001);
`else
      chk("bypass_after_rst", o[31:0], {d[30:0], 1'b0});
`endif

      // all-ones instruction -> BYPASS
      ir_scan(5'h1F, o5);
      chk("ir_capture", o5, 5'b00001);
      chk("instr_1f", instr, 5'h1F);
      dr_scan(4, 64'b1101, o);
      chk("bypass_pattern", o[3:0], 4'b1010);

      // user chain
      ir_scan(5'h10, o5);
      chk("user_sel_on", user_sel, 1'b1);
      dr_scan(8, {$urandom, $urandom}, o);
      ir_scan(5'h01, o5);
      d = {$urandom, $urandom};
      dr_scan(32, d, o);
`ifdef JTAG_IDCODE_EN
      chk("idcode_again", o[31:0], 32'h1000_0001);
`else
      chk("idc_is_bypass", o[31:0], {d[30:0], 1'b0});
`endif

      // unrecognised opcode -> BYPASS
      ir_scan(5'h07, o5);
      chk("user_sel_off", user_sel, 1'b0);
      dr_scan(6, {$urandom, $urandom}, o);

      // reset during the third IR shift
      ir_scan(5'h10, o5);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, t);
      cyc(0, 0, 1, 0, 0, 0, 0, 1, t);
      cyc(0, 0, 1, 0, 0, 0, 0, 1, t);
      cyc(1, 0, 1, 0, 0, 0, 0, 1, t);
      chk("rst_mid_instr", instr, RST_INSTR);
      chk("rst_mid_tdo", tdo, 1'b0);
      for (int i = 0; i < W; i++) begin
         cyc(0, 0, 1, 0, 0, 0, 0, 1, t);
         o5[i] = t;
      end
      chk("ir_cleared", o5, 5'b00000);
      idle(1);

      // randomized scans
      for (int k = 0; k < 40; k++) begin
         pick = $urandom_range(0, 4);
         case (pick)
            0:       op = 5'h01;
            1:       op = 5'h10;
            2:       op = 5'h07;
            3:       op = 5'h1F;
            default: op = 5'($urandom);
         endcase
         ir_scan(op, o5);
         chk("ir_capture_rand", o5, 5'b00001);
         n = $urandom_range(1, 40);
         d = {$urandom, $urandom};
         dr_scan(n, d, o);
         if ($urandom_range(0, 9) == 0) cyc(1, 0, 0, 0, 0, 0, 0, 0, t);
         idle($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
